// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: captures the MEM-stage result, selects the
// writeback source and destination, suppresses writes to $0, raises the
// WB-to-EX forwarding hits and counts retired instructions.
module mem_wb_stage #(
  parameter int unsigned LINK_REG = 31
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        InValid,
  input  logic        InRegWrite,
  input  logic        InMemToReg,
  input  logic        InLink,
  input  logic [4:0]  InWriteRegister,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemReadData,
  input  logic [31:0] PCPlus8,
  input  logic [4:0]  ExRs,
  input  logic [4:0]  ExRt,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic        FwdA,
  output logic        FwdB,
  output logic [31:0] Retired
);

  localparam logic [4:0] LinkRegNum = 5'(LINK_REG);

  logic        valid_q,      valid_d;
  logic        reg_write_q,  reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        link_q,       link_d;
  logic [4:0]  dest_q,       dest_d;
  logic [31:0] alu_q,        alu_d;
  logic [31:0] mem_data_q,   mem_data_d;
  logic [31:0] pc_plus8_q,   pc_plus8_d;
  logic [31:0] retired_q,    retired_d;

  // A simultaneous flush wins over a stall, so the hold only applies
  // when no flush is present.
  logic hold;
  logic wb_reg_nz;

  // Next-state selection: flush invalidates, stall holds, else capture.
  always_comb begin
    hold         = Stall & ~Flush;
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    link_d       = link_q;
    dest_d       = dest_q;
    alu_d        = alu_q;
    mem_data_d   = mem_data_q;
    pc_plus8_d   = pc_plus8_q;
    retired_d    = retired_q;

    // The instruction in the slot leaves the stage unless it is held;
    // a flushed edge still retires what was already here.
    if (valid_q && !hold) begin
      retired_d = retired_q + 32'd1;
    end

    if (Flush) begin
      // Payload is left as-is; with valid low it cannot reach any write.
      valid_d = 1'b0;
    end else if (!Stall) begin
      valid_d      = InValid;
      reg_write_d  = InRegWrite;
      mem_to_reg_d = InMemToReg;
      link_d       = InLink;
      dest_d       = InWriteRegister;
      alu_d        = ALUResult;
      mem_data_d   = MemReadData;
      pc_plus8_d   = PCPlus8;
    end
  end

  // Stage registers with synchronous reset overriding flush and stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      dest_q       <= 5'd0;
      alu_q        <= 32'd0;
      mem_data_q   <= 32'd0;
      pc_plus8_q   <= 32'd0;
      retired_q    <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      link_q       <= link_d;
      dest_q       <= dest_d;
      alu_q        <= alu_d;
      mem_data_q   <= mem_data_d;
      pc_plus8_q   <= pc_plus8_d;
      retired_q    <= retired_d;
    end
  end

  // Writeback source/destination, $0 guard and forwarding hits.
  always_comb begin
    if (link_q) begin
      WriteData = pc_plus8_q;
    end else if (mem_to_reg_q) begin
      WriteData = mem_data_q;
    end else begin
      WriteData = alu_q;
    end

    WriteRegister = link_q ? LinkRegNum : dest_q;
    wb_reg_nz     = (WriteRegister != 5'd0);
    RegWrite      = valid_q & reg_write_q & wb_reg_nz;
    FwdA          = RegWrite & (WriteRegister == ExRs);
    FwdB          = RegWrite & (WriteRegister == ExRt);
    Retired       = retired_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus pushes hand-computed
// expectations tagged with the clock edge they apply after; an
// independent monitor samples the outputs after each edge and compares.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush;
  logic        InValid, InRegWrite, InMemToReg, InLink;
  logic [4:0]  InWriteRegister, ExRs, ExRt;
  logic [31:0] ALUResult, MemReadData, PCPlus8;
  logic [31:0] WriteData, Retired;
  logic [4:0]  WriteRegister;
  logic        RegWrite, FwdA, FwdB;

  mem_wb_stage #(.LINK_REG(31)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .InValid(InValid), .InRegWrite(InRegWrite), .InMemToReg(InMemToReg),
    .InLink(InLink), .InWriteRegister(InWriteRegister),
    .ALUResult(ALUResult), .MemReadData(MemReadData), .PCPlus8(PCPlus8),
    .ExRs(ExRs), .ExRt(ExRt),
    .WriteData(WriteData), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite), .FwdA(FwdA), .FwdB(FwdB), .Retired(Retired)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned edge_n;
    string       name;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw;
    logic        fa;
    logic        fb;
    logic [31:0] ret;
    bit          data_dc;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endfunction

  // Monitor: sample just after each rising edge and retire matching entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      edge_n++;
      while (sb.size() > 0 && sb[0].edge_n <= edge_n) begin
        e = sb.pop_front();
        if (e.edge_n < edge_n) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s missed actual_edge=%0d required_edge=%0d", e.name, edge_n, e.edge_n);
        end else begin
          if (!e.data_dc) begin
            chk(e.name, "WriteData", WriteData, e.wd);
            chk(e.name, "WriteRegister", {27'd0, WriteRegister}, {27'd0, e.wr});
          end
          chk(e.name, "RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
          chk(e.name, "FwdA", {31'd0, FwdA}, {31'd0, e.fa});
          chk(e.name, "FwdB", {31'd0, FwdB}, {31'd0, e.fb});
          chk(e.name, "Retired", Retired, e.ret);
        end
      end
    end
  end

  task automatic ins(input logic v, input logic rw, input logic m2r, input logic lk,
                     input logic [4:0] wreg, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] pc8);
    InValid = v; InRegWrite = rw; InMemToReg = m2r; InLink = lk;
    InWriteRegister = wreg; ALUResult = alu; MemReadData = mem; PCPlus8 = pc8;
  endtask

  // Expectation for the outputs right after the next rising edge.
  task automatic expect_next(input string nm, input logic [31:0] wd, input logic [4:0] wr,
                             input logic rw, input logic fa, input logic fb,
                             input logic [31:0] ret, input bit dc);
    exp_t e;
    e.edge_n = edge_n + 1; e.name = nm; e.wd = wd; e.wr = wr; e.rw = rw;
    e.fa = fa; e.fb = fb; e.ret = ret; e.data_dc = dc;
    sb.push_back(e);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; ExRs = 5'd0; ExRt = 5'd0;
    ins(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    expect_next("reset1", 32'd0, 5'd0, 0, 0, 0, 32'd0, 0);
    @(negedge Clk);
    expect_next("reset2", 32'd0, 5'd0, 0, 0, 0, 32'd0, 0);

    // ALU writeback to $5
    @(negedge Clk); Reset = 1'b0;
    ins(1, 1, 0, 0, 5'd5, 32'h0000002A, 32'h0, 32'h0);
    expect_next("alu_wb", 32'h2A, 5'd5, 1, 0, 0, 32'd0, 0);
    @(negedge Clk); ins(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    expect_next("alu_retire", 32'd0, 5'd0, 0, 0, 0, 32'd1, 0);

    // Load into $8 with forward on Rs
    @(negedge Clk); ExRs = 5'd8; ExRt = 5'd9;
    ins(1, 1, 1, 0, 5'd8, 32'h00001234, 32'hDEADBEEF, 32'h0);
    expect_next("load_fwdA", 32'hDEADBEEF, 5'd8, 1, 1, 0, 32'd1, 0);
    @(negedge Clk); ExRs = 5'd3; ExRt = 5'd9;
    ins(1, 1, 0, 0, 5'd9, 32'h00000077, 32'h0, 32'h0);
    expect_next("alu_fwdB", 32'h77, 5'd9, 1, 0, 1, 32'd2, 0);

    // Link with MemToReg also set, destination forced to $31
    @(negedge Clk); ExRs = 5'd31; ExRt = 5'd0;
    ins(1, 1, 1, 1, 5'd0, 32'h66, 32'h55, 32'h00400010);
    expect_next("link", 32'h00400010, 5'd31, 1, 1, 0, 32'd3, 0);

    // Plain write to $0 is suppressed
    @(negedge Clk); ExRs = 5'd0; ExRt = 5'd0;
    ins(1, 1, 0, 0, 5'd0, 32'h99, 32'h0, 32'h0);
    expect_next("zero_reg", 32'h99, 5'd0, 0, 0, 0, 32'd4, 0);

    // Capture $3 = 0x11, then stall three edges with changing inputs
    @(negedge Clk); ExRt = 5'd3;
    ins(1, 1, 0, 0, 5'd3, 32'h11, 32'h0, 32'h0);
    expect_next("cap3", 32'h11, 5'd3, 1, 0, 1, 32'd5, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); Stall = 1'b1;
      ins(1, 1, 0, 0, 5'(10 + i), 32'hA0 + 32'(i), 32'h0, 32'h0);
      expect_next("stall_hold", 32'h11, 5'd3, 1, 0, 1, 32'd5, 0);
    end

    // Stall together with Flush acts as a flush and retires the held op
    @(negedge Clk); Flush = 1'b1;
    ins(1, 1, 0, 0, 5'd12, 32'hBB, 32'h0, 32'h0);
    expect_next("stall_flush", 32'h0, 5'd0, 0, 0, 0, 32'd6, 1);

    // Refill so a held instruction sits with Retired = 7
    @(negedge Clk); Flush = 1'b0; Stall = 1'b0;
    ins(1, 1, 0, 0, 5'd4, 32'h5, 32'h0, 32'h0);
    expect_next("refill", 32'h5, 5'd4, 1, 0, 0, 32'd6, 0);
    @(negedge Clk);
    ins(1, 1, 0, 0, 5'd6, 32'h66, 32'h0, 32'h0);
    expect_next("refill2", 32'h66, 5'd6, 1, 0, 0, 32'd7, 0);
    @(negedge Clk); Stall = 1'b1;
    ins(1, 1, 0, 0, 5'd7, 32'h77, 32'h0, 32'h0);
    expect_next("held7", 32'h66, 5'd6, 1, 0, 0, 32'd7, 0);

    // Reset during stall clears everything without retiring
    @(negedge Clk); Reset = 1'b1;
    expect_next("reset_mid", 32'd0, 5'd0, 0, 0, 0, 32'd0, 0);
    @(negedge Clk); Reset = 1'b0; Stall = 1'b0;
    ins(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    expect_next("post_reset", 32'd0, 5'd0, 0, 0, 0, 32'd0, 0);

    // Flush alone kills the incoming instruction
    @(negedge Clk); Flush = 1'b1;
    ins(1, 1, 0, 0, 5'd7, 32'h1, 32'h0, 32'h0);
    expect_next("flush_only", 32'h0, 5'd0, 0, 0, 0, 32'd0, 1);

    // Counter wrap: preload the retired count, then retire one instruction
    @(negedge Clk); Flush = 1'b0;
    force dut.retired_q = 32'hFFFFFFFF;
    ins(1, 1, 0, 0, 5'd2, 32'hC, 32'h0, 32'h0);
    expect_next("wrap_pre", 32'hC, 5'd2, 1, 0, 0, 32'hFFFFFFFF, 0);
    #1 release dut.retired_q;
    @(negedge Clk);
    ins(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    expect_next("wrap", 32'd0, 5'd0, 0, 0, 0, 32'd0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge Clk);
    #3;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending_entries=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
